// File: rtl/irq_ctrl.sv
// Eight-source interrupt controller: pending latch, mask/GIE, lowest-index priority,
// one-hot irq pulse, resume-address save and return redirect. Optional IRQ_CTRL_EDGE_EN.
module irq_ctrl #(
  parameter int CPU_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           irq_src,
  input  logic [CPU_WIDTH-1:0] resume_pc,
  input  logic                 irq_ret,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_addr,
  input  logic [7:0]           cfg_wdata,
  output logic [7:0]           cfg_rdata,
  output logic [7:0]           irq,
  output logic                 ret_valid,
  output logic [CPU_WIDTH-1:0] ret_pc,
  output logic [1:0]           dbg_state
);

  // Handshake: irq and ret_valid are single-cycle strobes with no ready;
  // the fetch stage must accept them in the cycle they are high.

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_SERVICE  = 2'd2,
    S_RETURN   = 2'd3
  } state_t;

  localparam logic [1:0] A_MASK = 2'd0;
  localparam logic [1:0] A_PEND = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;
  localparam logic [1:0] A_ISR  = 2'd3;

  state_t               state_q, state_d;
  logic [7:0]           mask_q, mask_d;
  logic                 gie_q, gie_d;
  logic [7:0]           pend_q, pend_d;
  logic [7:0]           isr_q, isr_d;
  logic [CPU_WIDTH-1:0] epc_q, epc_d;
  logic [7:0]           irq_q, irq_d;
  logic                 ret_valid_q, ret_valid_d;

  logic [7:0] set;
  logic [7:0] clr;
  logic [7:0] eligible;
  logic [7:0] winner;
  logic       take;

`ifdef IRQ_CTRL_EDGE_EN
  logic [7:0] src_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) src_q <= 8'h00;
    else        src_q <= irq_src;
  end

  assign set = irq_src & ~src_q;
`else
  assign set = irq_src;
`endif

  assign eligible = pend_q & mask_q;
  // Two's-complement trick isolates the lowest set bit.
  assign winner   = eligible & (~eligible + 8'd1);
  assign take     = (state_q == S_IDLE) && gie_q && (eligible != 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mask_q      <= 8'h00;
      gie_q       <= 1'b0;
      pend_q      <= 8'h00;
      isr_q       <= 8'h00;
      epc_q       <= '0;
      irq_q       <= 8'h00;
      ret_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      gie_q       <= gie_d;
      pend_q      <= pend_d;
      isr_q       <= isr_d;
      epc_q       <= epc_d;
      irq_q       <= irq_d;
      ret_valid_q <= ret_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (take) state_d = S_DISPATCH;
      S_DISPATCH: state_d = S_SERVICE;
      S_SERVICE:  if (irq_ret) state_d = S_RETURN;
      S_RETURN:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Strobes are computed one cycle early so they appear registered in DISPATCH/RETURN.
  always_comb begin
    irq_d       = take ? winner : 8'h00;
    ret_valid_d = (state_q == S_SERVICE) && irq_ret;
  end

  always_comb begin
    mask_d = mask_q;
    gie_d  = gie_q;
    isr_d  = isr_q;
    epc_d  = epc_q;
    clr    = 8'h00;
    if (cfg_we) begin
      case (cfg_addr)
        A_MASK:  mask_d = cfg_wdata;
        A_PEND:  clr    = cfg_wdata;
        A_CTRL:  gie_d  = cfg_wdata[0];
        default: ;
      endcase
    end
    // irq_q holds the winner latched on entry, so a late lower-index arrival cannot alter it.
    if (state_q == S_DISPATCH) begin
      clr   = clr | irq_q;
      isr_d = irq_q;
      epc_d = resume_pc;
    end
    if (state_q == S_RETURN) isr_d = 8'h00;
    pend_d = (pend_q & ~clr) | set;
  end

  always_comb begin
    cfg_rdata = 8'h00;
    case (cfg_addr)
      A_MASK:  cfg_rdata = mask_q;
      A_PEND:  cfg_rdata = pend_q;
      A_CTRL:  cfg_rdata = {7'b0, gie_q};
      A_ISR:   cfg_rdata = isr_q;
      default: cfg_rdata = 8'h00;
    endcase
  end

  assign irq       = irq_q;
  assign ret_valid = ret_valid_q;
  assign ret_pc    = epc_q;
  assign dbg_state = state_q;

endmodule
